// File: rtl/sa_weight_loader_pkg.sv
// rtl/sa_weight_loader_pkg.sv - shared FSM encoding, tile size and transpose table for the weight loader
// Purpose: single source of truth for the loader state encoding and the 3x3
//          tile geometry used by the loader and its address decoder.
// Ports:   none (package).
package sa_weight_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_RESP = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int CNT_W     = 4;
    localparam int TILE_SIZE = 9;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_SIZE - 1);

    // Column-major transpose of the 3x3 tile: entry k sits at bits [4k+3:4k],
    // giving offsets 0,3,6,1,4,7,2,5,8 for k = 0..8.
    localparam logic [4*TILE_SIZE-1:0] TRANSPOSE_TABLE = {
        4'd8, 4'd5, 4'd2, 4'd7, 4'd4, 4'd1, 4'd6, 4'd3, 4'd0
    };

endpackage

// File: rtl/sa_weight_address_decoder.sv
// rtl/sa_weight_address_decoder.sv - combinational issue-index to tile-offset decoder
// Purpose: maps the issue counter (0..8) onto the transposed memory offset.
// Ports:   cnt_i    - issue index, 4 bits
//          offset_o - offset from the tile base, ADDR_W bits (0 for cnt_i > 8)
module sa_weight_address_decoder
    import sa_weight_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [ADDR_W-1:0] offset_o
);

    logic [5:0] lsb;
    logic [3:0] entry;

    always_comb begin
        lsb   = {cnt_i, 2'b00};
        entry = 4'd0;
        // Out-of-range counts cannot occur in the loader; map them to 0 so the
        // dynamic select never reaches past the table.
        if (cnt_i <= LAST_CNT) begin
            entry = TRANSPOSE_TABLE[lsb +: 4];
        end
        offset_o = ADDR_W'(entry);
    end

endmodule

// File: rtl/sa_weight_loader.sv
// rtl/sa_weight_loader.sv - loads one transposed 3x3 weight tile from memory into the systolic array
// Purpose: on start, reads nine weights at base + transpose(cnt) and hands
//          each one to the array with a valid/ready handshake.
// Ports:   clk, rst_n            - clock, synchronous active-low reset
//          start, abort          - tile request / cancel
//          base_addr             - tile base, captured on accepted start
//          mem_rd_en, mem_addr   - memory read request
//          mem_rdata             - read data, one cycle after mem_rd_en
//          w_data, w_idx, w_valid, w_ready - weight stream to the array
//          busy, done            - status
module sa_weight_loader
    import sa_weight_loader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] w_data,
    output logic [3:0]        w_idx,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [3:0]          w_idx_q, w_idx_d;
    logic [ADDR_W-1:0]   offset;

    sa_weight_address_decoder #(
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .cnt_i    (cnt_q),
        .offset_o (offset)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            w_data_q <= '0;
            w_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            w_data_q <= w_data_d;
            w_idx_q  <= w_idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        w_data_d = w_data_q;
        w_idx_d  = w_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    base_d  = base_addr;
                end
            end
            ST_READ: begin
                state_d = abort ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    w_data_d = mem_rdata;
                    w_idx_d  = cnt_q;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                // Abort wins over a handshake in the same cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address wraps naturally modulo 2^ADDR_W.
    assign mem_addr  = base_q + offset;
    assign mem_rd_en = (state_q == ST_READ);
    assign w_valid   = (state_q == ST_SEND);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign w_data    = w_data_q;
    assign w_idx     = w_idx_q;

endmodule

// File: tb/tb_sa_weight_loader.sv
// tb/tb_sa_weight_loader.sv - self-checking bench for sa_weight_loader
module tb_sa_weight_loader;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] w_data;
    logic [3:0]    w_idx;
    logic          w_valid;
    logic          w_ready = 1'b1;
    logic          busy;
    logic          done;

    sa_weight_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: mem[i] = i+16; data is valid only the cycle after a read strobe.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? DW'(32'(mem_addr) + 16) : 8'hEE;
    end

    function automatic int exp_addr(input int base, input int k);
        return (base + (k % 3) * 3 + k / 3) % 64;
    endfunction

    // Behavioural model: tile progress as (active, weight k, cycle within weight p).
    bit m_active   = 1'b0;
    bit m_done_due = 1'b0;
    int m_k        = 0;
    int m_p        = 0;
    int m_base     = 0;

    int hs_count   = 0;
    int done_count = 0;
    int rd_count   = 0;
    int addr_q[$];
    int data_q[$];
    int idx_q[$];

    always @(negedge clk) begin
        bit exp_rd, exp_valid;
        exp_rd    = m_active && (m_p == 0);
        exp_valid = m_active && (m_p >= 2);
        check("mem_rd_en", mem_rd_en, exp_rd);
        check("w_valid", w_valid, exp_valid);
        check("busy", busy, m_active || m_done_due);
        check("done", done, m_done_due);
        if (exp_rd) check("mem_addr", mem_addr, exp_addr(m_base, m_k));
        if (exp_valid) begin
            check("w_data", w_data, (exp_addr(m_base, m_k) + 16) % 256);
            check("w_idx", w_idx, m_k);
        end

        if (mem_rd_en === 1'b1) begin
            rd_count++;
            addr_q.push_back(int'(mem_addr));
        end
        if (w_valid === 1'b1 && w_ready && !abort && rst_n) begin
            hs_count++;
            data_q.push_back(int'(w_data));
            idx_q.push_back(int'(w_idx));
        end
        if (done === 1'b1) done_count++;

        if (!rst_n) begin
            m_active = 1'b0; m_done_due = 1'b0; m_k = 0; m_p = 0;
        end else if (m_done_due) begin
            m_done_due = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_k = 0; m_p = 0; m_base = int'(base_addr);
            end
        end else if (abort) begin
            m_active = 1'b0;
        end else if (m_p < 2) begin
            m_p++;
        end else if (w_ready) begin
            m_k++;
            m_p = 0;
            if (m_k == 9) begin
                m_active   = 1'b0;
                m_done_due = 1'b1;
            end
        end
    end

    task automatic clear_obs();
        hs_count = 0; done_count = 0; rd_count = 0;
        addr_q.delete(); data_q.delete(); idx_q.delete();
    endtask

    task automatic pulse_start(input int b);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(b);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid_idx(input int idx);
        int n = 0;
        while (!(w_valid === 1'b1 && w_idx == 4'(idx)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_w_idx", w_valid, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_base0_seq(input string tag);
        int exp_seq[9] = '{16, 19, 22, 17, 20, 23, 18, 21, 24};
        check({tag, "_count"}, data_q.size(), 9);
        for (int i = 0; i < 9 && i < data_q.size(); i++) begin
            check({tag, "_data"}, data_q[i], exp_seq[i]);
            check({tag, "_idx"}, idx_q[i], i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_addr_seq[9] = '{60, 63, 2, 61, 0, 3, 62, 1, 4};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_mem_rd_en", mem_rd_en, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_w_data", w_data, 0);
        check("rst_w_idx", w_idx, 0);
        rst_n = 1'b1;

        // Basic tile, base 0, with latency pinned by literals.
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("lat_rd_en", mem_rd_en, 1'b1);
        check("lat_addr0", mem_addr, 0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check("lat_resp_valid", w_valid, 1'b0);
            if (n == 2) begin
                check("lat_first_valid", w_valid, 1'b1);
                check("lat_first_data", w_data, 16);
            end
        end
        check("lat_done_edges", n, 27);
        @(posedge clk); #1;
        check("busy_after_done", busy, 1'b0);
        check("done_width", done, 1'b0);
        check_base0_seq("t1");
        check("t1_done_count", done_count, 1);

        // Stall at w_idx=4 for five cycles.
        clear_obs();
        pulse_start(0);
        wait_valid_idx(4);
        w_ready = 1'b0;
        n = rd_count;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", w_valid, 1'b1);
            check("stall_data", w_data, 20);
            check("stall_rd_en", mem_rd_en, 1'b0);
            @(posedge clk); #1;
        end
        w_ready = 1'b1;
        check("stall_no_reads", rd_count, n);
        wait_done();
        check_base0_seq("t2");
        check("t2_done_count", done_count, 1);

        // Address wrap with base 60.
        clear_obs();
        pulse_start(60);
        wait_done();
        check("t3_addr_count", addr_q.size(), 9);
        for (int i = 0; i < 9 && i < addr_q.size(); i++) begin
            check("t3_addr", addr_q[i], exp_addr_seq[i]);
        end

        // Abort in SEND at w_idx=3 with w_ready=1.
        clear_obs();
        pulse_start(0);
        wait_valid_idx(3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", w_valid, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_hs", hs_count, 3);
        check("abort_no_done", done_count, 0);
        clear_obs();
        pulse_start(0);
        wait_done();
        check_base0_seq("t4");
        check("t4_done_count", done_count, 1);

        // Reset in RESP of w_idx=5.
        clear_obs();
        pulse_start(0);
        n = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr == 6'd7) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_read5", mem_rd_en, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", w_valid, 1'b0);
        check("mid_rst_rd_en", mem_rd_en, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_w_data", w_data, 0);
        check("mid_rst_w_idx", w_idx, 0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_count, 0);
        clear_obs();
        pulse_start(0);
        wait_done();
        check_base0_seq("t5");
        check("t5_done_count", done_count, 1);

        // Start while busy at w_idx=2 is ignored.
        clear_obs();
        pulse_start(0);
        wait_valid_idx(2);
        start = 1'b1;
        base_addr = 6'd30;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        check_base0_seq("t6");
        check("t6_hs", hs_count, 9);
        check("t6_done_count", done_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_weight_loader.md
SA_WEIGHT_LOADER -- requirements
Module: sa_weight_loader

Interface
REQ-001 Parameter DATA_W, default 8, weight width in bits.
REQ-002 Parameter ADDR_W, default 6, weight-memory address width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to load one 3x3 weight tile.
REQ-006 abort  input  1  synchronous cancel of the tile in progress.
REQ-007 base_addr  input  ADDR_W  tile base address; sampled when start is accepted.
REQ-008 mem_rd_en  output  1  weight-memory read strobe.
REQ-009 mem_addr  output  ADDR_W  weight-memory read address.
REQ-010 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-011 w_data  output  DATA_W  weight delivered to the systolic array.
REQ-012 w_idx  output  4  issue index (0..8) of the weight on w_data.
REQ-013 w_valid  output  1  w_data and w_idx are valid.
REQ-014 w_ready  input  1  systolic array accepts the weight when w_valid and w_ready are both 1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the 9th weight handshake.

Function
REQ-017 FSM states SHALL be IDLE, READ, RESP, SEND and DONE.
REQ-018 IDLE -> READ when start=1; cnt <= 0; base register <= base_addr.
REQ-019 READ: mem_rd_en=1; mem_addr = base register + decode(cnt), modulo 2^ADDR_W; next state RESP.
REQ-020 decode(cnt) SHALL map 0..8 to 0,3,6,1,4,7,2,5,8 (column-major transpose of the 3x3 tile).
REQ-021 RESP: w_data <= mem_rdata; w_idx <= cnt; next state SEND.
REQ-022 SEND: w_valid=1; w_data and w_idx held stable until the handshake.
REQ-023 SEND with handshake and cnt<8: cnt <= cnt+1; next state READ.
REQ-024 SEND with handshake and cnt=8: next state DONE.
REQ-025 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-026 start SHALL be ignored in every state except IDLE.
REQ-027 abort=1 in any non-IDLE state: next state IDLE; no done pulse; the current weight is dropped.
REQ-028 abort has priority over a simultaneous handshake.
REQ-029 mem_rd_en SHALL be 0 in every state except READ; w_valid SHALL be 0 in every state except SEND.
REQ-030 Latency with w_ready=1: start sampled at edge N gives first w_valid in cycle N+3; each weight takes 3 cycles; done follows the last handshake by one cycle.

Reset
REQ-031 rst_n=0 at a clock edge: state=IDLE, cnt=0, w_data=0, w_idx=0, base register=0.
REQ-032 Outputs during and after reset: mem_rd_en=0, w_valid=0, busy=0, done=0.
REQ-033 Reset mid-tile SHALL discard the tile; no done pulse.

Structure
REQ-034 State encoding, the tile size constant (9) and the transpose table SHALL be defined in a shared package.
REQ-035 The cnt->offset mapping SHALL be a combinational sub-module, sa_weight_address_decoder (4-bit cnt in, ADDR_W offset out), instantiated once.
REQ-036 The address adder, FSM and output registers SHALL live in sa_weight_loader.

Verification
REQ-037 Memory: mem[i] = i+16; base=0; w_ready=1; start pulse -> w_data sequence 16,19,22,17,20,23,18,21,24; w_idx 0..8; done one cycle after the last handshake; busy drops the following cycle.
REQ-038 Same setup; w_ready=0 for 5 cycles when w_idx=4 -> w_data holds 20 and w_valid holds 1 for all 5 cycles; no new mem_rd_en; sequence resumes with 23.
REQ-039 base=60 -> mem_addr sequence 60,63,2,61,0,3,62,1,4 (wrap modulo 64).
REQ-040 abort asserted in SEND at w_idx=3 while w_ready=1 -> IDLE next cycle; no handshake counted; no done; a new start restarts from w_idx=0.
REQ-041 rst_n=0 in RESP at w_idx=5 -> all outputs take reset values on the next edge; a later start delivers a full 9-weight tile.
REQ-042 start pulsed while busy at w_idx=2 -> ignored; exactly 9 weights and one done are produced.
